// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths and FSM encoding for the operand fetch stage
package operand_fetch_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAG_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, VALID = 2'd2} state_e;
endpackage

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: picks live write > earlier forward > bank data for one operand
module operand_forward_mux
  import operand_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              fwd_valid,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] op,
  output logic              match
);
  always_comb begin
    match = wb_write_enable && wb_write_address == src;
    op = match ? wb_write_data : fwd_valid ? fwd_data : rf_data;
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issues bank reads, forwards missed writes, hands operands to execute
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_src_a,
  input  logic [ADDR_W-1:0] in_src_b,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [ADDR_W-1:0] rf_read_addressA,
  output logic [ADDR_W-1:0] rf_read_addressB,
  input  logic [DATA_W-1:0] rf_read_dataA,
  input  logic [DATA_W-1:0] rf_read_dataB,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [ADDR_W-1:0] out_dst,
  output logic [TAG_W-1:0]  out_tag
);
  state_e state, state_nx;
  logic accept, fwd_a, fwd_b, hit_a, hit_b;
  logic [ADDR_W-1:0] src_a, src_b;
  logic [DATA_W-1:0] fwd_data, sel_a, sel_b;

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = accept ? READ :
               state == READ ? VALID :
               (state == VALID && !out_ready) ? VALID : IDLE;

  always_comb begin
    in_ready = rst_n && (state == IDLE || (state == VALID && out_ready));
    accept = in_valid && in_ready;
    out_valid = state == VALID;
    rf_read_addressA = accept ? in_src_a : src_a;
    rf_read_addressB = accept ? in_src_b : src_b;
  end

  operand_forward_mux u_mux_a (
    .src(src_a), .rf_data(rf_read_dataA), .fwd_valid(fwd_a), .fwd_data(fwd_data),
    .wb_write_enable(wb_write_enable), .wb_write_address(wb_write_address),
    .wb_write_data(wb_write_data), .op(sel_a), .match(hit_a)
  );

  operand_forward_mux u_mux_b (
    .src(src_b), .rf_data(rf_read_dataB), .fwd_valid(fwd_b), .fwd_data(fwd_data),
    .wb_write_enable(wb_write_enable), .wb_write_address(wb_write_address),
    .wb_write_data(wb_write_data), .op(sel_b), .match(hit_b)
  );

  // The bank's registered read misses a write at the accept edge, so remember it
  always_ff @(posedge clk)
    if (!rst_n) begin
      src_a <= '0;
      src_b <= '0;
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
      fwd_data <= '0;
      out_op_a <= '0;
      out_op_b <= '0;
      out_dst <= '0;
      out_tag <= '0;
    end else begin
      if (accept) begin
        src_a <= in_src_a;
        src_b <= in_src_b;
        fwd_a <= wb_write_enable && wb_write_address == in_src_a;
        fwd_b <= wb_write_enable && wb_write_address == in_src_b;
        fwd_data <= wb_write_data;
        out_dst <= in_dst;
        out_tag <= in_tag;
      end
      if (state == READ) begin
        out_op_a <= sel_a;
        out_op_b <= sel_b;
      end else if (state == VALID) begin
        if (hit_a) out_op_a <= wb_write_data;
        if (hit_b) out_op_b <= wb_write_data;
      end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table-driven vectors plus scoreboard queue against a bank model
module tb_operand_fetch;
  import operand_fetch_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [ADDR_W-1:0] in_src_a = 0, in_src_b = 0, in_dst = 0, rf_read_addressA, rf_read_addressB;
  logic [ADDR_W-1:0] wb_write_address = 0, out_dst;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  logic [DATA_W-1:0] rf_read_dataA, rf_read_dataB, wb_write_data = 0, out_op_a, out_op_b;
  logic wb_write_enable = 0;
  logic [DATA_W-1:0] bank [32];

  typedef struct {
    logic [ADDR_W-1:0] sa, sb, dst;
    logic [TAG_W-1:0] tag;
    logic w0;
    logic [ADDR_W-1:0] w0a;
    logic [DATA_W-1:0] w0d;
    logic w1;
    logic [ADDR_W-1:0] w1a;
    logic [DATA_W-1:0] w1d;
    logic [DATA_W-1:0] ea, eb;
  } vec_t;
  typedef struct {
    logic [ADDR_W-1:0] dst;
    logic [TAG_W-1:0] tag;
    logic [DATA_W-1:0] a, b;
  } exp_t;

  vec_t vt [7];
  exp_t sb [$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // Register bank with one-cycle registered read; a same-edge write is not seen by the read
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'h100 + i;
      bank[3] <= 32'h11;
      bank[4] <= 32'h22;
    end else if (wb_write_enable) bank[wb_write_address] <= wb_write_data;
    rf_read_dataA <= bank[rf_read_addressA];
    rf_read_dataB <= bank[rf_read_addressB];
  end

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_tag(in_tag),
    .rf_read_addressA(rf_read_addressA), .rf_read_addressB(rf_read_addressB),
    .rf_read_dataA(rf_read_dataA), .rf_read_dataB(rf_read_dataB),
    .wb_write_enable(wb_write_enable), .wb_write_address(wb_write_address),
    .wb_write_data(wb_write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dst(out_dst), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_write_enable = en;
    wb_write_address = a;
    wb_write_data = d;
  endtask

  // Present an instruction; push expectation when it will be accepted at the coming edge
  task automatic offer(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] sbr,
                       input logic [ADDR_W-1:0] dst, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    in_valid = 1;
    in_src_a = sa;
    in_src_b = sbr;
    in_dst = dst;
    in_tag = tag;
    #1;
    chk("in_ready", in_ready, 1);
    chk("rd_addr_a", rf_read_addressA, sa);
    chk("rd_addr_b", rf_read_addressB, sbr);
    if (in_ready) sb.push_back('{dst, tag, ea, eb});
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    chk({name, "_valid"}, out_valid, 1);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk({name, "_sb_empty"}, 1, 0);
      else begin
        e = sb.pop_front();
        chk({name, "_op_a"}, out_op_a, e.a);
        chk({name, "_op_b"}, out_op_b, e.b);
        chk({name, "_dst"}, out_dst, e.dst);
        chk({name, "_tag"}, out_tag, e.tag);
      end
    end
  endtask

  initial begin
    vt[0] = '{3, 4, 5, 8'h07, 0, 0, 0, 0, 0, 0, 32'h11, 32'h22};
    vt[1] = '{3, 4, 5, 8'h07, 1, 3, 32'hAA, 0, 0, 0, 32'hAA, 32'h22};
    vt[2] = '{3, 4, 6, 8'h21, 1, 4, 32'hBB, 1, 4, 32'hCC, 32'hAA, 32'hCC};
    vt[3] = '{7, 7, 1, 8'h33, 0, 0, 0, 1, 7, 32'h77, 32'h77, 32'h77};
    vt[4] = '{0, 9, 2, 8'h44, 1, 0, 32'h5, 0, 0, 0, 32'h5, 32'h109};
    vt[5] = '{9, 0, 3, 8'h55, 1, 9, 32'h99, 1, 0, 32'h0A, 32'h99, 32'h0A};
    vt[6] = '{1, 2, 4, 8'h66, 1, 5, 32'hEE, 0, 0, 0, 32'h101, 32'h102};

    in_valid = 1;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", out_op_a, 0);
    chk("rst_op_b", out_op_b, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_tag", out_tag, 0);
    in_valid = 0;
    rst_n = 1;
    step();

    foreach (vt[i]) begin
      offer(vt[i].sa, vt[i].sb, vt[i].dst, vt[i].tag, vt[i].ea, vt[i].eb);
      wb(vt[i].w0, vt[i].w0a, vt[i].w0d);
      step();
      in_valid = 0;
      chk("read_out_valid", out_valid, 0);
      wb(vt[i].w1, vt[i].w1a, vt[i].w1d);
      step();
      wb(0, 0, 0);
      pop_check("vec");
      step();
      chk("idle_out_valid", out_valid, 0);
    end

    // Stall with a snoop write on a held operand
    out_ready = 0;
    offer(3, 4, 9, 8'h77, 0, 0);
    void'(sb.pop_back());
    step();
    in_valid = 0;
    step();
    chk("hold_op_a0", out_op_a, 32'hAA);
    step();
    wb(1, 3, 32'h55);
    #1;
    chk("hold_in_ready", in_ready, 0);
    step();
    wb(0, 0, 0);
    chk("hold_valid", out_valid, 1);
    chk("hold_op_a", out_op_a, 32'h55);
    chk("hold_op_b", out_op_b, 32'hCC);
    chk("hold_dst", out_dst, 9);
    chk("hold_tag", out_tag, 8'h77);
    out_ready = 1;
    step();
    chk("hold_released", out_valid, 0);

    // Back-to-back: second accepted the same cycle the first is consumed
    offer(1, 2, 10, 8'hA1, 32'h101, 32'h102);
    step();
    in_src_a = 3;
    in_src_b = 4;
    in_dst = 11;
    in_tag = 8'hA2;
    #1;
    chk("b2b_read_ready", in_ready, 0);
    step();
    chk("b2b_in_ready", in_ready, 1);
    if (in_ready) sb.push_back('{5'd11, 8'hA2, 32'h55, 32'hCC});
    pop_check("b2b1");
    step();
    in_valid = 0;
    chk("b2b_gap", out_valid, 0);
    step();
    pop_check("b2b2");
    step();

    // Reset while READ discards the instruction
    offer(3, 4, 12, 8'hB0, 0, 0);
    step();
    sb.delete();
    rst_n = 0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    step();
    chk("mid_rst_valid2", out_valid, 0);
    in_valid = 0;
    rst_n = 1;
    step();
    offer(3, 4, 5, 8'h07, 32'h11, 32'h22);
    step();
    in_valid = 0;
    step();
    pop_check("post_rst");
    step();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1);
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Reader-side client of the register bank; feeds decoded instruction operands to the ALU.
- Accepts a decoded instruction (two source register numbers, one destination, one tag) over a valid/ready handshake.
- Drives the bank read addresses and captures the registered read data one cycle later.
- Forwards any bank write the registered read missed, and presents operands to the execute stage over a second valid/ready handshake.

Parameters:
DATA_W, 32, operand / register width
ADDR_W, 5, register address width (32 registers)
TAG_W, 8, opaque instruction tag passed through unchanged

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decoded instruction available
in_ready  out  1  block can accept instruction this cycle
in_src_a  in  ADDR_W  source register A number
in_src_b  in  ADDR_W  source register B number
in_dst  in  ADDR_W  destination register number, passed through
in_tag  in  TAG_W  tag, passed through
rf_read_addressA  out  ADDR_W  to bank read_addressA
rf_read_addressB  out  ADDR_W  to bank read_addressB
rf_read_dataA  in  DATA_W  from bank read_dataA, registered one cycle after address
rf_read_dataB  in  DATA_W  from bank read_dataB
wb_write_enable  in  1  any bank write committing at this edge; the integrator merges generic and fixed-address writes onto this port
wb_write_address  in  ADDR_W  address of that write
wb_write_data  in  DATA_W  data of that write
out_valid  out  1  operands valid
out_ready  in  1  execute stage accepts
out_op_a  out  DATA_W  operand A
out_op_b  out  DATA_W  operand B
out_dst  out  ADDR_W  passthrough
out_tag  out  TAG_W  passthrough

Behaviour:
Reset (rst_n low at an edge):
- State goes to IDLE; out_valid=0; out_op_a/b=0; out_dst=0; out_tag=0.
- Held read addresses go to 0; all pending forward flags are cleared.
- in_ready is forced 0 while rst_n is low.
- Reset mid-operation discards any in-flight instruction with no output.

FSM states:
- IDLE: nothing in flight.
- READ: addresses issued, bank data arrives this cycle.
- VALID: operands held on the outputs.

Handshake and addressing:
- in_ready = (state==IDLE) | (state==VALID & out_ready).
- Accept = in_valid & in_ready.
- rf_read_addressA/B are combinational: in_src_a/b when accept, else the held address register. The bank therefore samples the new addresses at the accept edge E0.

Transitions:
- IDLE -> READ on accept.
- READ -> VALID unconditionally at E1; outputs are loaded from rf_read_data with forwarding applied.
- VALID, out_ready & accept -> READ (back-to-back).
- VALID, out_ready & !accept -> IDLE.
- VALID, !out_ready -> stay in VALID and hold.

Latency and throughput:
- Accept edge E0 -> out_valid high from E1.
- Maximum throughput is one instruction per 2 cycles.

Forwarding (per operand, A and B independent; both forwarded if src_a==src_b):
- A write at E0 (accept edge) whose address matches the src is not seen by the bank's registered read. Record a forward flag and the data.
- A write at E1 (READ edge) whose address matches overrides both the E0 forward and the bank data.
- Priority at E1 capture: E1 write > E0 forward > rf_read_data.
- While in VALID, each write matching a held operand's src updates that operand at the edge, including an edge where out_ready=1. The downstream stage samples the pre-edge value.
- Register 0 is ordinary: there is no hardwired zero.

Other rules:
- in_dst/in_tag are captured at accept and appear on the outputs with out_valid.
- All outputs are stable while out_valid=1 & out_ready=0, except for snoop updates.
- out_valid must not drop without out_ready.

Decomposition:
- Shared package holds DATA_W, ADDR_W, TAG_W and the state encoding constants (IDLE=2'd0, READ=2'd1, VALID=2'd2).
- One natural sub-module: operand_forward_mux, instantiated twice. It takes src, bank data, the E0 flag/data and the live write port, and returns the selected operand plus a match flag.

Test Plan:
- Bank r3=0x11, r4=0x22; accept src_a=3, src_b=4, dst=5, tag=0x7 at E0 -> rf_read_addressA=3 and B=4 during the accept cycle; out_op_a=0x11, out_op_b=0x22, out_dst=5, out_tag=0x7, out_valid=1 from E1.
- Same as above, plus wb write r3<=0xAA at E0 -> out_op_a=0xAA, out_op_b=0x22.
- wb write r4<=0xBB at E0 and r4<=0xCC at E1 -> out_op_b=0xCC (latest wins).
- Hold out_ready=0 for 3 cycles; write r3<=0x55 in cycle 2 -> out_op_a changes to 0x55, out_op_b/out_dst/out_tag unchanged, out_valid stays 1.
- Back-to-back: two instructions offered continuously with out_ready=1 -> second accepted in the same cycle the first is consumed; out_valid pulses every other cycle with correct operands.
- rst_n=0 during READ -> next cycle out_valid=0, state IDLE, in_ready=0 while reset is held; after release, a new accept behaves as in scenario 1.
